// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back.
// Optional build macro CTRL_TRAP_EN: illegal instructions park in TRAP instead of retiring as NOPs.
module mc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       ir_we,
  output logic       iord,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic [1:0] wb_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_sign,
  output logic [2:0] alu_op,
  output logic       retire,
  output logic [3:0] state
);

  localparam logic [3:0] S_RESET  = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_EXEC_R = 4'd3;
  localparam logic [3:0] S_EXEC_I = 4'd4;
  localparam logic [3:0] S_ADDR   = 4'd5;
  localparam logic [3:0] S_MEM_RD = 4'd6;
  localparam logic [3:0] S_MEM_WR = 4'd7;
  localparam logic [3:0] S_WB_R   = 4'd8;
  localparam logic [3:0] S_WB_I   = 4'd9;
  localparam logic [3:0] S_WB_LD  = 4'd10;
  localparam logic [3:0] S_BRANCH = 4'd11;
  localparam logic [3:0] S_JUMP   = 4'd12;
  localparam logic [3:0] S_TRAP   = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;
  localparam logic [2:0] ALU_SRL = 3'd6;
  localparam logic [2:0] ALU_LUI = 3'd7;

  logic [3:0] state_q;
  logic [3:0] state_nxt;

  logic is_rtype, is_jr, r_alu_ok, r_shift, is_imm, is_mem, is_br, is_jmp, illegal;

  function automatic logic [2:0] r_alu_op(input logic [5:0] fn);
    case (fn)
      FN_SUB:  r_alu_op = ALU_SUB;
      FN_AND:  r_alu_op = ALU_AND;
      FN_OR:   r_alu_op = ALU_OR;
      FN_SLT:  r_alu_op = ALU_SLT;
      FN_SLL:  r_alu_op = ALU_SLL;
      FN_SRL:  r_alu_op = ALU_SRL;
      default: r_alu_op = ALU_ADD;
    endcase
  endfunction

  // Instruction classification; R-type funct legality is resolved here so DECODE can dispatch it.
  always_comb begin
    is_rtype = (opcode == OP_RTYPE);
    r_shift  = (funct == FN_SLL) || (funct == FN_SRL);
    r_alu_ok = r_shift || (funct == FN_ADD) || (funct == FN_SUB) ||
               (funct == FN_AND) || (funct == FN_OR) || (funct == FN_SLT);
    is_jr    = is_rtype && (funct == FN_JR);
    is_imm   = (opcode == OP_ADDI) || (opcode == OP_ANDI) ||
               (opcode == OP_ORI)  || (opcode == OP_LUI);
    is_mem   = (opcode == OP_LW) || (opcode == OP_SW);
    is_br    = (opcode == OP_BEQ) || (opcode == OP_BNE);
    is_jmp   = (opcode == OP_J) || (opcode == OP_JAL) || is_jr;
    illegal  = !((is_rtype && r_alu_ok) || is_imm || is_mem || is_br || is_jmp);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_RESET;
    else     state_q <= state_nxt;
  end

  assign state = state_q;

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_RESET:  state_nxt = S_FETCH;
      S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        if (is_jmp)                     state_nxt = S_JUMP;
        else if (is_rtype && r_alu_ok)  state_nxt = S_EXEC_R;
        else if (is_imm)                state_nxt = S_EXEC_I;
        else if (is_mem)                state_nxt = S_ADDR;
        else if (is_br)                 state_nxt = S_BRANCH;
        else
`ifdef CTRL_TRAP_EN
          state_nxt = S_TRAP;
`else
          state_nxt = S_FETCH;
`endif
      end
      S_EXEC_R: state_nxt = S_WB_R;
      S_EXEC_I: state_nxt = S_WB_I;
      S_ADDR:   state_nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (mem_ready) state_nxt = S_WB_LD;
      S_MEM_WR: if (mem_ready) state_nxt = S_FETCH;
      S_WB_R, S_WB_I, S_WB_LD, S_BRANCH, S_JUMP: state_nxt = S_FETCH;
      S_TRAP:   state_nxt = S_TRAP;
      default:  state_nxt = S_RESET;
    endcase
  end

  // Outputs are forced low while rst is high so no strobe survives into the reset window.
  always_comb begin
    pc_we     = 1'b0;
    pc_src    = 2'd0;
    ir_we     = 1'b0;
    iord      = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    reg_we    = 1'b0;
    reg_dst   = 2'd0;
    wb_src    = 2'd0;
    alu_src_a = 2'd0;
    alu_src_b = 2'd0;
    ext_sign  = 1'b0;
    alu_op    = ALU_ADD;
    retire    = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_rd    = 1'b1;
          alu_src_b = 2'd1;
          ir_we     = mem_ready;
          pc_we     = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = 2'd3;
          ext_sign  = 1'b1;
`ifndef CTRL_TRAP_EN
          retire    = illegal;
`endif
        end
        S_EXEC_R: begin
          alu_src_a = r_shift ? 2'd2 : 2'd1;
          alu_op    = r_alu_op(funct);
        end
        S_EXEC_I: begin
          alu_src_a = 2'd1;
          alu_src_b = 2'd2;
          case (opcode)
            OP_ANDI: alu_op = ALU_AND;
            OP_ORI:  alu_op = ALU_OR;
            OP_LUI:  alu_op = ALU_LUI;
            default: begin
              alu_op   = ALU_ADD;
              ext_sign = 1'b1;
            end
          endcase
        end
        S_ADDR: begin
          alu_src_a = 2'd1;
          alu_src_b = 2'd2;
          ext_sign  = 1'b1;
        end
        S_MEM_RD: begin
          mem_rd = 1'b1;
          iord   = 1'b1;
        end
        S_MEM_WR: begin
          mem_wr = 1'b1;
          iord   = 1'b1;
          retire = mem_ready;
        end
        S_WB_R: begin
          reg_we  = 1'b1;
          reg_dst = 2'd1;
          retire  = 1'b1;
        end
        S_WB_I: begin
          reg_we = 1'b1;
          retire = 1'b1;
        end
        S_WB_LD: begin
          reg_we = 1'b1;
          wb_src = 2'd1;
          retire = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 2'd1;
          alu_op    = ALU_SUB;
          pc_src    = 2'd1;
          pc_we     = (opcode == OP_BEQ) ? zero : !zero;
          retire    = 1'b1;
        end
        S_JUMP: begin
          pc_we  = 1'b1;
          retire = 1'b1;
          if (is_jr) begin
            pc_src = 2'd3;
          end else begin
            pc_src = 2'd2;
            if (opcode == OP_JAL) begin
              reg_we  = 1'b1;
              reg_dst = 2'd2;
              wb_src  = 2'd2;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl: a per-instruction phase list predicts state and outputs every cycle.
module tb_mc_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pc_we, ir_we, iord, mem_rd, mem_wr, reg_we, ext_sign, retire;
  logic [1:0] pc_src, reg_dst, wb_src, alu_src_a, alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we),
    .iord(iord), .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_we(reg_we),
    .reg_dst(reg_dst), .wb_src(wb_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ext_sign(ext_sign), .alu_op(alu_op),
    .retire(retire), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       rdy;
    logic       zero;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we, iord, mem_rd, mem_wr, reg_we;
    logic [1:0] reg_dst, wb_src, a, b;
    logic       ext;
    logic [2:0] op;
    logic       retire;
  } step_t;

  step_t q[$];
  int checks = 0;
  int errors = 0;
  int retire_seen = 0;
  int retire_exp = 0;
  logic [20:0] outs;

  assign outs = {pc_we, pc_src, ir_we, iord, mem_rd, mem_wr, reg_we, reg_dst,
                 wb_src, alu_src_a, alu_src_b, ext_sign, alu_op, retire};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [20:0] exp_outs(input step_t s);
    return {s.pc_we, s.pc_src, s.ir_we, s.iord, s.mem_rd, s.mem_wr, s.reg_we,
            s.reg_dst, s.wb_src, s.a, s.b, s.ext, s.op, s.retire};
  endfunction

  function automatic step_t blank(input logic [3:0] st);
    step_t s;
    s      = '0;
    s.st   = st;
    s.rdy  = 1'($urandom);
    s.zero = 1'($urandom);
    return s;
  endfunction

  // Phase list for one instruction, straight from the instruction-class behaviour.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input int fst,
                       input int mst, input logic z);
    step_t s;
    for (int i = 0; i <= fst; i++) begin
      s = blank(4'd1); s.mem_rd = 1; s.b = 2'd1;
      s.rdy = (i == fst);
      s.ir_we = s.rdy; s.pc_we = s.rdy;
      q.push_back(s);
    end
    s = blank(4'd2); s.b = 2'd3; s.ext = 1;
    if (op == 6'h00 && fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02}) begin
      q.push_back(s);
      s = blank(4'd3); s.a = (fn == 6'h00 || fn == 6'h02) ? 2'd2 : 2'd1;
      case (fn)
        6'h22: s.op = 3'd1;  6'h24: s.op = 3'd2;  6'h25: s.op = 3'd3;
        6'h2A: s.op = 3'd4;  6'h00: s.op = 3'd5;  6'h02: s.op = 3'd6;
        default: s.op = 3'd0;
      endcase
      q.push_back(s);
      s = blank(4'd8); s.reg_we = 1; s.reg_dst = 2'd1; s.retire = 1; q.push_back(s);
    end else if (op inside {6'h08, 6'h0C, 6'h0D, 6'h0F}) begin
      q.push_back(s);
      s = blank(4'd4); s.a = 2'd1; s.b = 2'd2;
      case (op)
        6'h08: begin s.op = 3'd0; s.ext = 1; end
        6'h0C: s.op = 3'd2;
        6'h0D: s.op = 3'd3;
        default: s.op = 3'd7;
      endcase
      q.push_back(s);
      s = blank(4'd9); s.reg_we = 1; s.retire = 1; q.push_back(s);
    end else if (op == 6'h23 || op == 6'h2B) begin
      q.push_back(s);
      s = blank(4'd5); s.a = 2'd1; s.b = 2'd2; s.ext = 1; q.push_back(s);
      for (int i = 0; i <= mst; i++) begin
        s = blank(op == 6'h23 ? 4'd6 : 4'd7); s.iord = 1;
        s.rdy = (i == mst);
        if (op == 6'h23) s.mem_rd = 1;
        else begin s.mem_wr = 1; s.retire = s.rdy; end
        q.push_back(s);
      end
      if (op == 6'h23) begin
        s = blank(4'd10); s.reg_we = 1; s.wb_src = 2'd1; s.retire = 1; q.push_back(s);
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      q.push_back(s);
      s = blank(4'd11); s.a = 2'd1; s.op = 3'd1; s.pc_src = 2'd1; s.retire = 1;
      s.zero = z; s.pc_we = (op == 6'h04) ? z : !z;
      q.push_back(s);
    end else if (op == 6'h02 || op == 6'h03 || (op == 6'h00 && fn == 6'h08)) begin
      q.push_back(s);
      s = blank(4'd12); s.pc_we = 1; s.retire = 1;
      s.pc_src = (op == 6'h00) ? 2'd3 : 2'd2;
      if (op == 6'h03) begin s.reg_we = 1; s.reg_dst = 2'd2; s.wb_src = 2'd2; end
      q.push_back(s);
    end else begin
`ifdef CTRL_TRAP_EN
      q.push_back(s);
      for (int i = 0; i < 10; i++) q.push_back(blank(4'd13));
`else
      s.retire = 1;
      q.push_back(s);
`endif
    end
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] fn, input int fst,
                     input int mst, input logic z);
    step_t s;
    q.delete();
    build(op, fn, fst, mst, z);
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge clk);
      opcode = op; funct = fn; mem_ready = s.rdy; zero = s.zero;
      #1;
      check($sformatf("state op%0h fn%0h", op, fn), 32'(state), 32'(s.st));
      check($sformatf("outs st%0d op%0h fn%0h", s.st, op, fn), 32'(outs), 32'(exp_outs(s)));
      retire_exp += int'(s.retire);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (retire === 1'b1) retire_seen++;
  end

  initial begin
    step_t s;
    logic [5:0] op, fn;
    int kind;
    rst = 1'b1; opcode = '0; funct = '0; mem_ready = 1'b0; zero = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", 32'(state), 32'd0);
    check("reset_outs", 32'(outs), 32'd0);

    // Release into a FETCH stall, then pull reset mid-cycle.
    @(negedge clk); rst = 1'b0; mem_ready = 1'b0;
    @(negedge clk); #1;
    s = '0; s.mem_rd = 1; s.b = 2'd1;
    check("stall_state", 32'(state), 32'd1);
    check("stall_outs", 32'(outs), 32'(exp_outs(s)));
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_outs", 32'(outs), 32'd0);
    @(negedge clk); rst = 1'b0; mem_ready = 1'b1; #1;
    check("rel_state0", 32'(state), 32'd0);
    @(negedge clk); #1;
    check("rel_state1", 32'(state), 32'd1);
    check("rel_fetch_we", 32'({pc_we, ir_we}), 32'b11);
    @(negedge clk); #1;
    check("rel_state2", 32'(state), 32'd2);
    check("rel_decode_we", 32'({pc_we, ir_we}), 32'b00);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;

    // Directed cases from the instruction classes.
    run(6'h00, 6'h20, 0, 0, 1'b0);
    run(6'h23, 6'h11, 0, 3, 1'b0);
    run(6'h04, 6'h00, 0, 0, 1'b1);
    run(6'h05, 6'h00, 0, 0, 1'b1);
    run(6'h03, 6'h00, 0, 0, 1'b0);
`ifndef CTRL_TRAP_EN
    run(6'h3F, 6'h00, 0, 0, 1'b0);
    run(6'h00, 6'h3F, 1, 0, 1'b0);
`endif

    for (int n = 0; n < 300; n++) begin
      kind = int'($urandom_range(0, 17));
      fn = 6'($urandom);
      case (kind)
        0: begin op = 6'h00; fn = 6'h20; end
        1: begin op = 6'h00; fn = 6'h22; end
        2: begin op = 6'h00; fn = 6'h24; end
        3: begin op = 6'h00; fn = 6'h25; end
        4: begin op = 6'h00; fn = 6'h2A; end
        5: begin op = 6'h00; fn = 6'h00; end
        6: begin op = 6'h00; fn = 6'h02; end
        7: begin op = 6'h00; fn = 6'h08; end
        8: op = 6'h08;
        9: op = 6'h0C;
        10: op = 6'h0D;
        11: op = 6'h0F;
        12: op = 6'h23;
        13: op = 6'h2B;
        14: op = $urandom_range(0, 1) ? 6'h04 : 6'h05;
        15: op = $urandom_range(0, 1) ? 6'h02 : 6'h03;
`ifndef CTRL_TRAP_EN
        16: op = 6'h3F;
        default: begin op = 6'h00; fn = 6'h3F; end
`else
        default: begin op = 6'h00; fn = 6'h20; end
`endif
      endcase
      run(op, fn, int'($urandom_range(0, 3)) & int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)), 1'($urandom));
    end

`ifdef CTRL_TRAP_EN
    run(6'h3F, 6'h00, 0, 0, 1'b0);
    rst = 1'b1;
    #1;
    check("trap_rst_state", 32'(state), 32'd0);
    @(negedge clk); rst = 1'b0;
`endif

    @(negedge clk); #3;
    check("retire_count", 32'(retire_seen), 32'(retire_exp));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
